// File: rtl/npu_pkg.sv
// Shared definitions for the NPU SPI command frontend.
//   - cmd_code_e : host command codes carried in the top byte of a frame
//   - OP_*       : operation codes the core knows by name (others pass through)
//   - *_POS      : LSB position of each field in a complete FRAME_W=32 frame
//   - npu_cmd_t  : command register presented to the core
package npu_pkg;

  typedef enum logic [7:0] {
    CMD_WRITE  = 8'h01,
    CMD_START  = 8'h02,
    CMD_READ   = 8'h03,
    CMD_STATUS = 8'h04
  } cmd_code_e;

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_CONV = 3'd3;

  localparam int CMD_POS    = 24;
  localparam int TILE_I_POS = 21;
  localparam int TILE_J_POS = 18;
  localparam int OP_POS     = 15;
  localparam int DATA_POS   = 0;
  localparam int RESP_W     = 8;

  typedef struct packed {
    logic [7:0] code;
    logic [2:0] tile_i;
    logic [2:0] tile_j;
    logic [2:0] op;
    logic [7:0] data;
  } npu_cmd_t;

  // Codes that produce a command for the core at the end of the frame.
  function automatic logic is_cmd_frame(input logic [7:0] code);
    return (code == CMD_WRITE) || (code == CMD_START);
  endfunction

endpackage

// File: rtl/npu_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with edge pulses.
// Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   async_i    : asynchronous input pin
//   sync_o     : synchronised level
//   rise_o     : one-clk pulse on a synchronised 0->1 transition
//   fall_o     : one-clk pulse on a synchronised 1->0 transition
// All flops reset to 0. For cs_n this means a chip select that is already
// low when reset releases never produces a fall pulse, so the frontend only
// starts on a genuinely fresh cs_n fall.
module npu_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STG-1:0] sync_q;
  logic                prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], async_i};
      prev_q <= sync_q[SYNC_STG-1];
    end
  end

  assign sync_o = sync_q[SYNC_STG-1];
  assign rise_o = sync_q[SYNC_STG-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STG-1] & prev_q;

endmodule

// File: rtl/npu_spi_frontend.sv
// SPI-slave (mode 0) command frontend of the NPU, entirely in the clk domain.
// Frames are FRAME_W bits, MSB first: cmd[31:24] tile_i[23:21] tile_j[20:18]
// op[17:15] reserved[14:8] data[7:0].
// Ports:
//   clk, rst_n            : core clock, asynchronous active-low reset
//   sclk, cs_n, mosi      : SPI pins from the host (asynchronous)
//   miso                  : SPI response bit, driven only during a read response
//   cmd_valid/cmd_ready   : command handshake to the core
//   cmd_code/tile_i/tile_j/op/data : command fields, stable while cmd_valid
//   rd_req, rd_tile_i/j, rd_op : one-clk read request to the result memory
//   rd_data               : result byte, valid one clk after rd_req
//   core_busy, core_done  : core status inputs
//   done                  : registered copy of core_done
// Build option: define NPU_SPI_STATUS_EN to enable the STATUS (0x04) read,
// which returns {5'b0, overflow, core_busy, core_done}. Without it 0x04 is
// an unknown command and the overflow flag is internal only.
module npu_spi_frontend
  import npu_pkg::*;
#(
  parameter int FRAME_W  = 32,
  parameter int SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_code,
  output logic [2:0] cmd_tile_i,
  output logic [2:0] cmd_tile_j,
  output logic [2:0] cmd_op,
  output logic [7:0] cmd_data,
  output logic       rd_req,
  output logic [2:0] rd_tile_i,
  output logic [2:0] rd_tile_j,
  output logic [2:0] rd_op,
  input  logic [7:0] rd_data,
  input  logic       core_busy,
  input  logic       core_done,
  output logic       done
);

  localparam int CNT_W    = $clog2(FRAME_W + 1);
  localparam int HDR_BITS = FRAME_W - RESP_W;
  // Field positions while only the header has been shifted in.
  localparam int H_CMD    = CMD_POS - RESP_W;
  localparam int H_TI     = TILE_I_POS - RESP_W;
  localparam int H_TJ     = TILE_J_POS - RESP_W;
  localparam int H_OP     = OP_POS - RESP_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_RDREQ,  // rd_req on the wire this clk
    S_RDLAT,  // rd_data valid this clk
    S_RESP,
    S_DRAIN   // frame consumed, ignore further bits until cs_n rises
  } state_e;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  npu_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(sclk),
    .sync_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  npu_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .async_i(cs_n),
    .sync_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  npu_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .async_i(mosi),
    .sync_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [FRAME_W-1:0] shift_q, shift_d, shift_nxt;
  logic [7:0]         resp_q, resp_d, resp_byte, hdr_cmd;
  logic               miso_q, miso_d;
  logic               is_stat_q, is_stat_d;
  logic               rd_req_q, rd_req_d;
  logic [2:0]         rd_tile_i_q, rd_tile_i_d;
  logic [2:0]         rd_tile_j_q, rd_tile_j_d;
  logic [2:0]         rd_op_q, rd_op_d;
  npu_cmd_t           cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               overflow_q, overflow_d;
  logic               done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    resp_d      = resp_q;
    miso_d      = miso_q;
    is_stat_d   = is_stat_q;
    rd_req_d    = 1'b0;
    rd_tile_i_d = rd_tile_i_q;
    rd_tile_j_d = rd_tile_j_q;
    rd_op_d     = rd_op_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q & ~cmd_ready;
    overflow_d  = overflow_q;
    shift_nxt   = {shift_q[FRAME_W-2:0], mosi_s};
    cnt_inc     = cnt_q + CNT_W'(1);
    hdr_cmd     = shift_nxt[H_CMD +: 8];
    resp_byte   = is_stat_q ? resp_q : rd_data;

    case (state_q)
      S_IDLE: miso_d = 1'b0;
      S_SHIFT: begin
        miso_d = 1'b0;
        if (sclk_rise) begin
          shift_d = shift_nxt;
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_W'(HDR_BITS)) begin
            // Header complete: reads branch off here, unknown codes are dropped.
            if (hdr_cmd == CMD_READ) begin
              rd_req_d    = 1'b1;
              rd_tile_i_d = shift_nxt[H_TI +: 3];
              rd_tile_j_d = shift_nxt[H_TJ +: 3];
              rd_op_d     = shift_nxt[H_OP +: 3];
              is_stat_d   = 1'b0;
              state_d     = S_RDREQ;
            end
`ifdef NPU_SPI_STATUS_EN
            else if (hdr_cmd == CMD_STATUS) begin
              resp_d    = {5'b0, overflow_q, core_busy, core_done};
              is_stat_d = 1'b1;
              state_d   = S_RDREQ;
            end
`endif
            else if (!is_cmd_frame(hdr_cmd)) begin
              state_d = S_DRAIN;
            end
          end else if (cnt_inc == CNT_W'(FRAME_W)) begin
            state_d = S_DRAIN;
            if (cmd_valid_q && !cmd_ready) begin
              overflow_d = 1'b1;
            end else begin
              cmd_d.code   = shift_nxt[CMD_POS +: 8];
              cmd_d.tile_i = shift_nxt[TILE_I_POS +: 3];
              cmd_d.tile_j = shift_nxt[TILE_J_POS +: 3];
              cmd_d.op     = shift_nxt[OP_POS +: 3];
              cmd_d.data   = (shift_nxt[CMD_POS +: 8] == CMD_START) ?
                             8'h00 : shift_nxt[DATA_POS +: 8];
              cmd_valid_d  = 1'b1;
            end
          end
        end
      end
      S_RDREQ: state_d = S_RDLAT;
      S_RDLAT: begin
        // With sclk at clk/4 the first fall can coincide with this clk,
        // so bit 7 may go straight from the freshly arrived byte.
        state_d = S_RESP;
        if (sclk_fall) begin
          miso_d = resp_byte[7];
          resp_d = {resp_byte[6:0], 1'b0};
        end else begin
          resp_d = resp_byte;
        end
      end
      S_RESP: begin
        if (sclk_fall) begin
          miso_d = resp_q[7];
          resp_d = {resp_q[6:0], 1'b0};
        end
      end
      S_DRAIN: miso_d = 1'b0;
      default: begin
        state_d = S_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    if (cs_rise) begin
      // A status read clears overflow only once its frame has ended.
      if (is_stat_q) overflow_d = 1'b0;
      state_d   = S_IDLE;
      miso_d    = 1'b0;
      rd_req_d  = 1'b0;
      is_stat_d = 1'b0;
    end
    if (cs_fall) begin
      state_d   = S_SHIFT;
      cnt_d     = '0;
      miso_d    = 1'b0;
      is_stat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      resp_q      <= '0;
      miso_q      <= 1'b0;
      is_stat_q   <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_tile_i_q <= '0;
      rd_tile_j_q <= '0;
      rd_op_q     <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      resp_q      <= resp_d;
      miso_q      <= miso_d;
      is_stat_q   <= is_stat_d;
      rd_req_q    <= rd_req_d;
      rd_tile_i_q <= rd_tile_i_d;
      rd_tile_j_q <= rd_tile_j_d;
      rd_op_q     <= rd_op_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      overflow_q  <= overflow_d;
      done_q      <= core_done;
    end
  end

  assign miso       = miso_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_q.code;
  assign cmd_tile_i = cmd_q.tile_i;
  assign cmd_tile_j = cmd_q.tile_j;
  assign cmd_op     = cmd_q.op;
  assign cmd_data   = cmd_q.data;
  assign rd_req     = rd_req_q;
  assign rd_tile_i  = rd_tile_i_q;
  assign rd_tile_j  = rd_tile_j_q;
  assign rd_op      = rd_op_q;
  assign done       = done_q;

  // Synchroniser outputs and bits this frontend has no use for.
  logic unused_sig;
`ifdef NPU_SPI_STATUS_EN
  assign unused_sig = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall, shift_q[FRAME_W-1]};
`else
  assign unused_sig = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall, shift_q[FRAME_W-1],
                        core_busy};
`endif

endmodule

// File: tb/tb_npu_spi_frontend.sv
// Directed-vector bench for npu_spi_frontend with a queue scoreboard:
// stimulus pushes expected commands, read requests and MISO bytes; one
// monitor process pops and compares whenever the DUT presents them.
module tb_npu_spi_frontend;
  import npu_pkg::*;

  localparam int HALF = 5;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n, sclk, cs_n, mosi, cmd_ready, core_busy, core_done;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] rd_mem;
  logic       miso, cmd_valid, rd_req, done;
  logic [7:0] cmd_code, cmd_data;
  logic [2:0] cmd_tile_i, cmd_tile_j, cmd_op, rd_tile_i, rd_tile_j, rd_op;

  int n_checks = 0;
  int n_errors = 0;

  npu_cmd_t   exp_cmd_q[$];
  logic [8:0] exp_rd_q[$];
  logic [7:0] exp_resp_q[$];
  logic [7:0] obs_resp_q[$];

  npu_spi_frontend dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_tile_i(cmd_tile_i), .cmd_tile_j(cmd_tile_j), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rd_req(rd_req), .rd_tile_i(rd_tile_i),
    .rd_tile_j(rd_tile_j), .rd_op(rd_op), .rd_data(rd_data),
    .core_busy(core_busy), .core_done(core_done), .done(done)
  );

  always #5 clk = ~clk;

  // Core result memory: byte appears exactly one clk after rd_req.
  always @(posedge clk) rd_data <= rd_req ? rd_mem : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic npu_cmd_t mk_cmd(input logic [7:0] code, input logic [2:0] ti,
                                      input logic [2:0] tj, input logic [2:0] op,
                                      input logic [7:0] data);
    npu_cmd_t c;
    c.code = code; c.tile_i = ti; c.tile_j = tj; c.op = op; c.data = data;
    return c;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clock bits [first,last) of w; MISO is sampled before each rise from bit 24 on.
  task automatic spi_bits(input logic [31:0] w, input int first, input int last,
                          output logic [7:0] rb);
    rb = 8'h00;
    for (int i = first; i < last; i++) begin
      mosi = w[31-i];
      wait_clk(HALF);
      if (i >= 24) rb = {rb[6:0], miso};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] w, input int nbits, input logic keep_resp);
    logic [7:0] rb;
    cs_n = 1'b0;
    wait_clk(4);
    spi_bits(w, 0, nbits, rb);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    if (keep_resp) obs_resp_q.push_back(rb);
  endtask

  // Scoreboard monitor.
  initial begin
    npu_cmd_t   ec;
    logic [8:0] er;
    logic [7:0] ob;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL cmd_unexpected: got code=0x%0h data=0x%0h, required no command",
                   cmd_code, cmd_data);
        end else begin
          ec = exp_cmd_q.pop_front();
          check("cmd_fields", {cmd_code, cmd_tile_i, cmd_tile_j, cmd_op, cmd_data}, 32'(ec));
        end
      end
      if (rst_n && rd_req) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rd_req_unexpected: got %0d/%0d/%0d, required no request",
                   rd_tile_i, rd_tile_j, rd_op);
        end else begin
          er = exp_rd_q.pop_front();
          check("rd_req_fields", {rd_tile_i, rd_tile_j, rd_op}, 32'(er));
        end
      end
      if (obs_resp_q.size() > 0) begin
        ob = obs_resp_q.pop_front();
        if (exp_resp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL miso_unexpected: got 0x%0h, required no response", ob);
        end else begin
          check("miso_byte", ob, exp_resp_q.pop_front());
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [7:0] rb;
    npu_cmd_t   ca;
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    cmd_ready = 1'b0; core_busy = 1'b0; core_done = 1'b0; rd_mem = 8'h00;
    #1;
    check("rst_miso", miso, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_done", done, 0);
    check("rst_cmd_fields", {cmd_code, cmd_tile_i, cmd_tile_j, cmd_op, cmd_data}, 0);
    check("rst_rd_fields", {rd_tile_i, rd_tile_j, rd_op}, 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);

    // WRITE i=2 j=5 op=MUL data=A5
    cmd_ready = 1'b1;
    exp_cmd_q.push_back(mk_cmd(CMD_WRITE, 3'd2, 3'd5, OP_MUL, 8'hA5));
    frame(32'h015400A5, 32, 1'b0);

    // READ i=7 j=7 op=CONV, core returns 3C -> MISO 0,0,1,1,1,1,0,0
    rd_mem = 8'h3C;
    exp_rd_q.push_back({3'd7, 3'd7, OP_CONV});
    exp_resp_q.push_back(8'h3C);
    frame(32'h03FD8000, 32, 1'b1);

    // Abort after 12 bits, then a full START (data forced to 0)
    frame(32'h015400A5, 12, 1'b0);
    exp_cmd_q.push_back(mk_cmd(CMD_START, 3'd3, 3'd6, OP_MUL, 8'h00));
    frame(32'h02780099, 32, 1'b0);

    // Unknown command: consumed, MISO stays 0
    exp_resp_q.push_back(8'h00);
    frame(32'h7E000000, 32, 1'b1);

    // done is core_done delayed by one clk
    core_done = 1'b1;
    check("done_latency", done, 0);
    wait_clk(1);
    check("done_follow", done, 1);
    core_done = 1'b0;
    wait_clk(1);
    check("done_clear", done, 0);

    // Core not ready: first WRITE held, second frame dropped with overflow
    cmd_ready = 1'b0;
    ca = mk_cmd(CMD_WRITE, 3'd4, 3'd0, OP_CONV, 8'h5A);
    frame(32'h0181805A, 32, 1'b0);
    frame(32'h022D8077, 32, 1'b0);
    check("ovf_hold_valid", cmd_valid, 1);
    check("ovf_hold_fields", {cmd_code, cmd_tile_i, cmd_tile_j, cmd_op, cmd_data}, 32'(ca));
    check("overflow_set", dut.overflow_q, 1);
    exp_cmd_q.push_back(ca);
    cmd_ready = 1'b1;
    wait_clk(3);

    // STATUS with busy=1 done=0
    core_busy = 1'b1;
`ifdef NPU_SPI_STATUS_EN
    exp_resp_q.push_back(8'h06);
    frame(32'h04000000, 32, 1'b1);
    exp_resp_q.push_back(8'h02);
    frame(32'h04000000, 32, 1'b1);
    check("overflow_cleared", dut.overflow_q, 0);
`else
    exp_resp_q.push_back(8'h00);
    frame(32'h04000000, 32, 1'b1);
    exp_resp_q.push_back(8'h00);
    frame(32'h04000000, 32, 1'b1);
    check("overflow_kept", dut.overflow_q, 1);
`endif
    core_busy = 1'b0;

    // Reset in the middle of a READ response
    rd_mem = 8'hFF;
    exp_rd_q.push_back({3'd7, 3'd7, OP_CONV});
    cs_n = 1'b0;
    wait_clk(4);
    spi_bits(32'h03FD8000, 0, 26, rb);
    rst_n = 1'b0;
    #1;
    check("midrst_miso", miso, 0);
    check("midrst_cmd_valid", cmd_valid, 0);
    check("midrst_rd_req", rd_req, 0);
    check("midrst_cmd_fields", {cmd_code, cmd_tile_i, cmd_tile_j, cmd_op, cmd_data}, 0);
    check("midrst_rd_fields", {rd_tile_i, rd_tile_j, rd_op}, 0);
    wait_clk(3);
    rst_n = 1'b1;
    spi_bits(32'h03FD8000, 26, 32, rb);
    check("midrst_miso_tail", rb, 0);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    exp_cmd_q.push_back(mk_cmd(CMD_WRITE, 3'd0, 3'd1, 3'd5, 8'hC3));
    frame(32'h010680C3, 32, 1'b0);

    for (int k = 0; k < 200; k++) begin
      if (exp_cmd_q.size() == 0 && exp_rd_q.size() == 0 && obs_resp_q.size() == 0) break;
      wait_clk(1);
    end
    check("exp_cmd_left", exp_cmd_q.size(), 0);
    check("exp_rd_left", exp_rd_q.size(), 0);
    check("exp_resp_left", exp_resp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
